dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter and sequencer for the single-port 256x32 data memory.
//  - Port A: core load/store unit. Port B: host/debug loader.
//  - Serialises both ports onto one memory port using fixed priority for A, with a starvation limit that guarantees B service.
//  - Drives the memory's addr/write_data/memwrite/memread and returns its one-cycle-registered read_data to the owning requester.
// PARAMETERS
//  ADDR_W      32   address width; word-index addressing
//  DATA_W      32   data width
//  DEPTH       256  memory words; used by the optional address check
//  STARVE_MAX  4    consecutive A grants allowed while B waits; 1..15
// PORTS
//  clk         in   1       clock
//  reset       in   1       reset, synchronous, active-low
//  a_req       in   1       A request; sampled only in IDLE
//  a_we        in   1       A: 1=write, 0=read
//  a_addr      in   ADDR_W  A word address
//  a_wdata     in   DATA_W  A write data
//  a_gnt       out  1       A accepted; 1-cycle pulse
//  a_rvalid    out  1       A completion; 1-cycle pulse; reads and writes
//  a_rdata     out  DATA_W  A read data; valid with a_rvalid on reads, else 0
//  a_err       out  1       A address error; qualified by a_rvalid
//  b_*         -    -       same seven signals for port B
//  mem_addr    out  ADDR_W  to memory addr
//  mem_wdata   out  DATA_W  to memory write_data
//  mem_write   out  1       to memory memwrite
//  mem_read    out  1       to memory memread
//  mem_rdata   in   DATA_W  from memory read_data; valid the cycle after mem_read
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - state=IDLE, starve_cnt=0; all outputs 0.
//    - mem_write/mem_read held 0 so the memory preload is never disturbed.
//    - An in-flight access is dropped with no rvalid.
//  - FSM: IDLE -> ACCESS -> RESP -> IDLE. One access per 3 cycles; no arbitration in ACCESS or RESP.
//  - IDLE arbitration:
//    - Only one req: that port wins.
//    - Both: A wins unless starve_cnt==STARVE_MAX, in which case B wins.
//    - Winner's we/addr/wdata latched into owner regs; go to ACCESS.
//  - starve_cnt:
//    - +1 when A wins while b_req=1.
//    - Cleared when B wins, or when b_req=0 at arbitration.
//    - Saturates at STARVE_MAX.
//  - ACCESS:
//    - mem_addr/mem_wdata driven from latched regs.
//    - mem_write=we, mem_read=~we.
//    - Owner's gnt=1; go to RESP.
//  - RESP:
//    - Owner's rvalid=1.
//    - Owner's rdata=mem_rdata on reads, 0 on writes; other port's rdata=0.
//    - Go to IDLE.
//  - Latency: req high at edge N (IDLE) -> gnt in cycle N+1 -> rvalid in cycle N+2.
//  - Requester rules:
//    - Hold req/we/addr/wdata stable until gnt.
//    - Deassert req by the cycle after gnt; a req still high in IDLE is a new access.
//  - Simultaneous events: a req arriving outside IDLE waits; nothing is lost while req is held.
//  - Back-to-back: a write followed by a read to the same address returns the new data.
// CONFIGURATION
//  DMEM_ARB_ADDR_CHECK_EN defined:
//    - addr >= DEPTH is flagged at arbitration.
//    - ACCESS still pulses gnt, but mem_write=mem_read=0.
//    - RESP pulses rvalid with err=1 and rdata=0.
//  Not defined:
//    - a_err/b_err tied 0.
//    - Address passed through unchecked.
// STRUCTURE
//  - Package dmem_arb_pkg:
//    - state encoding IDLE/ACCESS/RESP.
//    - owner encoding OWN_A/OWN_B.
//    - default widths and DEPTH constant.
//  - Sub-module dmem_arb_pick: combinational winner select plus starve_cnt next-value logic.
//  - Top level holds the FSM, latched request regs and output muxing.
// TESTING
//  1. Hold reset=0 for 2 cycles -> all outputs 0, mem_write=mem_read=0, busy=0.
//  2. A read addr 3 alone -> cycle N+1: a_gnt=1, mem_read=1, mem_addr=3; cycle N+2: a_rvalid=1, a_rdata=12.
//  3. B write addr 5 data 99, then A read addr 5 -> b_rvalid with b_rdata=0; a_rdata=99.
//  4. a_req and b_req held high, STARVE_MAX=4 -> grant order A,A,A,A,B,A,A,A,A,B.
//  5. reset=0 during ACCESS of B write addr 7 -> no rvalid, state IDLE; subsequent A read addr 7 returns 67.
//  6. A read addr 300: macro defined -> a_err=1, a_rdata=0, no mem strobe; macro undefined -> mem_addr=300, mem_read=1, a_err=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// Holds FSM/owner encodings and default widths used across the slice.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;
  localparam int SMAX_DEF   = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter (one per port).
// master = load/store unit or loader; slave = arbiter.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Winner select for the arbiter: fixed priority to A, with B forced
// through once A has won STARVE_MAX times in a row while B waited.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = SMAX_DEF
) (
  input  logic             a_req_i,
  input  logic             b_req_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             any_o,
  output owner_e           owner_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);

  logic at_max;

  assign at_max = (cnt_i == MAX);

  always_comb begin
    any_o   = a_req_i | b_req_i;
    owner_o = OWN_A;
    cnt_o   = cnt_i;
    unique case (1'b1)
      (b_req_i && (!a_req_i || at_max)): begin
        owner_o = OWN_B;
        cnt_o   = '0;
      end
      (a_req_i && b_req_i && !at_max): begin
        cnt_o = cnt_i + 1'b1;
      end
      (a_req_i && !b_req_i): begin
        cnt_o = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises ports A and B onto the single-port data memory.
// DMEM_ARB_ADDR_CHECK_EN enables the out-of-range address error path.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_MAX = SMAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     a,
  dmem_arbiter_if.slave     b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pick_any;
  owner_e            pick_own;
  logic [CNT_W-1:0]  pick_cnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_bad;

  dmem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .a_req_i (a.req),
    .b_req_i (b.req),
    .cnt_i   (cnt_q),
    .any_o   (pick_any),
    .owner_o (pick_own),
    .cnt_o   (pick_cnt)
  );

  always_comb begin
    sel_we    = a.we;
    sel_addr  = a.addr;
    sel_wdata = a.wdata;
    if (pick_own == OWN_B) begin
      sel_we    = b.we;
      sel_addr  = b.addr;
      sel_wdata = b.wdata;
    end
  end

`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign sel_bad = (sel_addr >= ADDR_W'(DEPTH));
`else
  assign sel_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_A;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = ACCESS;
          owner_d = pick_own;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = sel_bad;
          cnt_d   = pick_cnt;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic acc, rsp, own_a, own_b, rd_ok;

  assign acc   = (state_q == ACCESS);
  assign rsp   = (state_q == RESP);
  assign own_a = (owner_q == OWN_A);
  assign own_b = (owner_q == OWN_B);
  assign rd_ok = rsp & ~we_q & ~err_q;

  // Strobes are gated by reset so an access caught mid-flight never lands.
  assign mem_addr  = acc ? addr_q  : '0;
  assign mem_wdata = acc ? wdata_q : '0;
  assign mem_write = reset & acc & we_q  & ~err_q;
  assign mem_read  = reset & acc & ~we_q & ~err_q;
  assign busy      = (state_q != IDLE);

  assign a.gnt    = acc & own_a;
  assign b.gnt    = acc & own_b;
  assign a.rvalid = rsp & own_a;
  assign b.rvalid = rsp & own_b;
  assign a.rdata  = (rd_ok & own_a) ? mem_rdata : '0;
  assign b.rdata  = (rd_ok & own_b) ? mem_rdata : '0;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign a.err = rsp & own_a & err_q;
  assign b.err = rsp & own_b & err_q;
`else
  assign a.err = 1'b0;
  assign b.err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cases plus random
// two-port traffic against a behavioural memory/arbitration model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int SMAX = 4;
  localparam bit CHK =
`ifdef DMEM_ARB_ADDR_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    bit          p;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if a ();
  dmem_arbiter_if b ();

  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, busy;

  dmem_arbiter #(
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] pre(input int i);
    return (i == 7) ? 32'd67 : 32'(i * 4);
  endfunction

  // Memory device: one-cycle registered read data
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= pre(i);
    end else begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  function automatic void flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endfunction

  logic [31:0] ref_mem [256];
  req_t        win_q[$];
  rsp_t        rsp_a[$], rsp_b[$];
  bit          gnt_log[$];
  int          streak;
  bit          exp_gnt, exp_rv_a, exp_rv_b;

  // Monitor and reference model, sampled on the falling edge
  initial begin
    req_t r;
    rsp_t e;
    bit   gp, oob;
    forever begin
      @(negedge clk);
      if (preload)
        for (int i = 0; i < 256; i++) ref_mem[i] = pre(i);
      if (!reset) begin
        win_q.delete();
        rsp_a.delete();
        rsp_b.delete();
        streak = 0;
        exp_gnt = 0;
        exp_rv_a = 0;
        exp_rv_b = 0;
        chk("rst_strobe", {mem_write, mem_read}, 0);
        continue;
      end
      if (a.rvalid) begin
        if (rsp_a.size() == 0) flag("a_rvalid_unexp");
        else begin
          e = rsp_a.pop_front();
          chk("a_rdata", a.rdata, e.rdata);
          chk("a_err", a.err, e.err);
        end
      end else begin
        if (exp_rv_a) begin flag("a_rvalid_missing"); rsp_a.delete(); end
        chk("a_idle", {a.rdata, a.err}, 0);
      end
      if (b.rvalid) begin
        if (rsp_b.size() == 0) flag("b_rvalid_unexp");
        else begin
          e = rsp_b.pop_front();
          chk("b_rdata", b.rdata, e.rdata);
          chk("b_err", b.err, e.err);
        end
      end else begin
        if (exp_rv_b) begin flag("b_rvalid_missing"); rsp_b.delete(); end
        chk("b_idle", {b.rdata, b.err}, 0);
      end
      exp_rv_a = 0;
      exp_rv_b = 0;
      if (a.gnt || b.gnt) begin
        gp = b.gnt;
        if (a.gnt && b.gnt) flag("gnt_both");
        if (win_q.size() == 0) flag("gnt_unexp");
        else begin
          r = win_q.pop_front();
          chk("gnt_owner", gp, r.p);
          gnt_log.push_back(gp);
          oob = CHK && (r.addr >= 32'd256);
          chk("mem_write", mem_write, r.we && !oob);
          chk("mem_read", mem_read, !r.we && !oob);
          if (!oob) chk("mem_addr", mem_addr, r.addr);
          if (!oob && r.we) chk("mem_wdata", mem_wdata, r.wdata);
          e.err = oob;
          e.rdata = (oob || r.we) ? 32'd0 : ref_mem[r.addr[7:0]];
          if (!oob && r.we) ref_mem[r.addr[7:0]] = r.wdata;
          if (r.p) begin rsp_b.push_back(e); exp_rv_b = 1; end
          else begin rsp_a.push_back(e); exp_rv_a = 1; end
        end
      end else if (exp_gnt) begin
        flag("gnt_missing");
        win_q.delete();
      end
      exp_gnt = 0;
      if (!busy && (a.req || b.req)) begin
        r.p = b.req && (!a.req || streak == SMAX);
        if (r.p) begin
          r.we = b.we; r.addr = b.addr; r.wdata = b.wdata;
          streak = 0;
        end else begin
          r.we = a.we; r.addr = a.addr; r.wdata = a.wdata;
          streak = b.req ? ((streak == SMAX) ? SMAX : streak + 1) : 0;
        end
        win_q.push_back(r);
        exp_gnt = 1;
      end
    end
  end

  task automatic issue(input bit p, input bit we,
                       input logic [31:0] ad, input logic [31:0] wd);
    bit ok = 0;
    if (p) begin b.we = we; b.addr = ad; b.wdata = wd; b.req = 1; end
    else   begin a.we = we; a.addr = ad; a.wdata = wd; a.req = 1; end
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      ok = p ? b.gnt : a.gnt;
    end
    if (p) b.req = 0; else a.req = 0;
    if (!ok) flag(p ? "b_gnt_timeout" : "a_gnt_timeout");
  endtask

  task automatic do_reset(input int n);
    reset = 0;
    repeat (n) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
    chk("drain", win_q.size() + rsp_a.size() + rsp_b.size(), 0);
  endtask

  task automatic rnd_port(input bit p);
    int n;
    logic [31:0] ad;
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 3);
      repeat (n) @(posedge clk);
      if (n > 0) #1;
      ad = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(250, 270))
                                        : 32'($urandom_range(0, 15));
      issue(p, 1'($urandom_range(0, 1)), ad, $urandom);
    end
  endtask

  bit exp_ord [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    a.req = 0; a.we = 0; a.addr = 0; a.wdata = 0;
    b.req = 0; b.we = 0; b.addr = 0; b.wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {a.gnt, a.rvalid, a.err, b.gnt, b.rvalid, b.err,
                     mem_write, mem_read, busy}, 0);
    chk("rst_bus", {mem_addr, mem_wdata}, 0);
    chk("rst_rdata", {a.rdata, b.rdata}, 0);
    preload = 0;
    reset = 1;
    @(posedge clk); #1;

    issue(0, 0, 32'd3, 0);
    issue(1, 1, 32'd5, 32'd99);
    issue(0, 0, 32'd5, 0);
    drain();

    do_reset(2);
    gnt_log.delete();
    a.we = 0; a.addr = 1; b.we = 0; b.addr = 2;
    a.req = 1; b.req = 1;
    for (int i = 0; i < 100 && gnt_log.size() < 10; i++) @(posedge clk);
    #1;
    a.req = 0; b.req = 0;
    if (gnt_log.size() < 10) flag("order_timeout");
    else for (int k = 0; k < 10; k++)
      chk($sformatf("order%0d", k), gnt_log[k], exp_ord[k]);
    drain();

    b.we = 1; b.addr = 7; b.wdata = 32'd555; b.req = 1;
    begin
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(posedge clk); #1;
        ok = b.gnt;
      end
      if (!ok) flag("rst_gnt_timeout");
    end
    reset = 0;
    b.req = 0;
    @(posedge clk); #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rv", {a.rvalid, b.rvalid}, 0);
    @(posedge clk); #1;
    reset = 1;
    issue(0, 0, 32'd7, 0);
    issue(0, 0, 32'd300, 0);
    drain();

    fork
      rnd_port(0);
      rnd_port(1);
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
